// File: rtl/mult_unit.sv
// mult_unit: fixed-latency shift-add multiplier (WIDTH RUN steps, then FIXUP, then DONE).
// Define MULT_SIGNED_EN to honour is_signed via magnitude capture and a FIXUP negate.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   mcand_q, addend, sum, mag_a, mag_b, hi_q, lo_q;
    logic [WIDTH:0]     carry;
    logic [2*WIDTH-1:0] acc_q, acc_d, res;
    logic               neg_q, neg_d, busy_q, done_q;

    assign addend   = acc_q[0] ? mcand_q : '0;
    assign carry[0] = 1'b0;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .x (acc_q[WIDTH+i]),
                .y (addend[i]),
                .ci(carry[i]),
                .s (sum[i]),
                .co(carry[i+1])
            );
        end
    endgenerate
    // carry-out becomes the new MSB, so the shift never loses the top bit
    assign acc_d = {carry[WIDTH], sum, acc_q[WIDTH-1:1]};
    assign res   = neg_q ? -acc_q : acc_q;
`ifdef MULT_SIGNED_EN
    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
    assign neg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`else
    logic unused_sign;
    assign unused_sign = is_signed;
    assign mag_a       = a;
    assign mag_b       = b;
    assign neg_d       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    busy_q <= start;
                    if (start) begin
                        mcand_q <= mag_a;
                        acc_q   <= {{WIDTH{1'b0}}, mag_b};
                        neg_q   <= neg_d;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= FIXUP;
                end
                FIXUP: begin
                    {hi_q, lo_q} <= res;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed checks of mult_unit (WIDTH=32); done is expected on the
// 34th rising edge counting the start-accept edge as the first.
module tb_mult_unit;
    logic        clk, reset, start, is_signed;
    logic [31:0] a, b, hi, lo;
    logic        busy, done;
    int          total = 0;
    int          bad = 0;

    mult_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input logic sv, input string tag);
        a = av;
        b = bv;
        is_signed = sv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        is_signed = ~sv;
        check({tag, ".busy_after_accept"}, busy, 1);
        check({tag, ".done_after_accept"}, done, 0);
    endtask

    task automatic finish(input logic [31:0] eh, input logic [31:0] el, input int glitch, input string tag);
        logic [31:0] ph, pl;
        logic early, moved;
        ph = hi;
        pl = lo;
        early = 1'b0;
        moved = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (k == glitch) begin
                start = 1'b1;
                a = 32'd1;
                b = 32'd1;
            end
            tick();
            start = 1'b0;
            early |= done;
            moved |= (hi !== ph) || (lo !== pl);
        end
        check({tag, ".busy_fixup"}, busy, 1);
        check({tag, ".early_done"}, early, 0);
        check({tag, ".hilo_moved"}, moved, 0);
        tick();
        check({tag, ".done"}, done, 1);
        check({tag, ".busy_done"}, busy, 0);
        check({tag, ".hi"}, hi, eh);
        check({tag, ".lo"}, lo, el);
    endtask

    initial begin
        logic seen;
        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.hi", hi, 0);
        check("rst.lo", lo, 0);
        reset = 1'b0;
        tick();

        launch(32'd3, 32'd5, 1'b0, "3x5");
        finish(32'h0, 32'hF, 0, "3x5");
        tick();
        check("3x5.done_drop", done, 0);
        check("3x5.lo_hold", lo, 32'hF);

        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max");
        finish(32'hFFFF_FFFE, 32'h0000_0001, 0, "max");
        tick();

        launch(32'd0, 32'd12345, 1'b0, "zero");
        finish(32'h0, 32'h0, 0, "zero");
        tick();

        launch(32'hFFFF_FFFD, 32'd5, 1'b1, "neg3x5");
`ifdef MULT_SIGNED_EN
        finish(32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, "neg3x5");
`else
        finish(32'h0000_0004, 32'hFFFF_FFF1, 0, "neg3x5");
`endif
        tick();

        launch(32'h8000_0000, 32'h8000_0000, 1'b1, "minxmin");
        finish(32'h4000_0000, 32'h0, 0, "minxmin");
        tick();

        launch(32'h8000_0000, 32'd1, 1'b1, "minx1");
`ifdef MULT_SIGNED_EN
        finish(32'hFFFF_FFFF, 32'h8000_0000, 0, "minx1");
`else
        finish(32'h0, 32'h8000_0000, 0, "minx1");
`endif
        tick();

        launch(32'd7, 32'd9, 1'b0, "ignore");
        finish(32'h0, 32'd63, 10, "ignore");
        tick();
        check("ignore.no_restart", busy, 0);

        launch(32'd7, 32'd9, 1'b0, "abort");
        for (int k = 1; k <= 11; k++) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.hi", hi, 0);
        check("abort.lo", lo, 0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            seen |= done | busy;
        end
        check("abort.no_done", seen, 0);

        launch(32'd6, 32'd7, 1'b0, "b2b1");
        finish(32'h0, 32'd42, 0, "b2b1");
        launch(32'd2, 32'd2, 1'b0, "b2b2");
        finish(32'h0, 32'd4, 0, "b2b2");
        tick();
        check("b2b.idle", busy | done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL provide port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL provide port start, input, 1, request to begin a multiply.
REQ-005 SHALL provide port is_signed, input, 1, selects MULT (1) or MULTU (0) semantics.
REQ-006 SHALL provide port a, input, WIDTH, multiplicand.
REQ-007 SHALL provide port b, input, WIDTH, multiplier.
REQ-008 SHALL provide port busy, output, 1, high while a multiply is in progress.
REQ-009 SHALL provide port done, output, 1, one-cycle pulse when hi/lo become valid.
REQ-010 SHALL provide port hi, output, WIDTH, upper half of the 2*WIDTH product.
REQ-011 SHALL provide port lo, output, WIDTH, lower half of the 2*WIDTH product.

Function
REQ-012 SHALL implement states IDLE, RUN, FIXUP, DONE.
REQ-013 In IDLE or DONE with start=1, SHALL capture a, b and is_signed, clear the accumulator, load a step counter with WIDTH, and enter RUN.
REQ-014 In RUN, each cycle SHALL add the multiplicand to the upper accumulator half if the current multiplier LSB is 1 (else add 0), then shift {carry_out, upper, lower} right by one bit and decrement the counter.
REQ-015 The per-step addition SHALL use a WIDTH-bit ripple chain of the team's full_adder cell, with carry-in 0 and the carry-out kept as the shift-in bit.
REQ-016 RUN SHALL last exactly WIDTH cycles, then go to FIXUP; FIXUP SHALL last 1 cycle, then go to DONE; DONE SHALL last 1 cycle, then go to IDLE.
REQ-017 Latency SHALL be fixed: done asserts WIDTH+2 cycles after the start-accept edge, independent of operand values, including zero operands.
REQ-018 busy SHALL be 1 in RUN and FIXUP, and 0 in IDLE and DONE.
REQ-019 done SHALL be 1 only in DONE.
REQ-020 hi/lo SHALL update only at the FIXUP->DONE edge, and SHALL hold their value until the next such edge; they SHALL not show intermediate accumulator values.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 start in DONE SHALL be accepted in the same way as in IDLE (back-to-back throughput of one result per WIDTH+2 cycles).
REQ-023 Inputs a, b and is_signed SHALL be sampled only at the start-accept edge; later changes SHALL have no effect.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and accumulator=0.
REQ-025 reset SHALL take priority over start, and SHALL abort any in-flight multiply without producing done.
REQ-026 The first start after reset is released SHALL behave as a normal start from IDLE.

Configuration
REQ-027 Macro MULT_SIGNED_EN defined: when is_signed=1, a and b SHALL be converted to magnitudes at capture, and FIXUP SHALL two's-complement negate the 2*WIDTH result if the operand signs differed.
REQ-028 Macro MULT_SIGNED_EN defined: the most negative operand (e.g. 0x80000000) SHALL be treated as magnitude 2^(WIDTH-1) and SHALL give the correct product.
REQ-029 Macro MULT_SIGNED_EN undefined: is_signed SHALL be ignored, all multiplies SHALL be unsigned, and FIXUP SHALL pass the result through unchanged, so latency is identical in both builds.

Verification
REQ-030 Reset, then start with a=3, b=5, is_signed=0 -> done at cycle 34 after accept; hi=0x00000000, lo=0x0000000F.
REQ-031 a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 With MULT_SIGNED_EN: a=0xFFFFFFFD (-3), b=5, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; same stimulus without MULT_SIGNED_EN -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-033 Start a=7, b=9; pulse start with a=1, b=1 at cycle 10 -> second start ignored; hi=0, lo=63 at cycle 34.
REQ-034 Start a=7, b=9; assert reset at cycle 12 -> next cycle busy=0, hi=lo=0, and no done pulse occurs.
REQ-035 Start in the DONE cycle with a=2, b=2 -> accepted; done is followed by a second done 34 cycles later with lo=4.
